// File: rtl/csr_trap_controller_pkg.sv
// Shared types and constants for the machine-mode CSR/trap sequencer:
// CSR file select, CSR addresses, op encodings, mstatus bit positions, FSM states.
package csr_trap_controller_pkg;

    typedef enum logic [2:0] {
        CSR_MSTATUS  = 3'd0,
        CSR_MIE      = 3'd1,
        CSR_MTVEC    = 3'd2,
        CSR_MSCRATCH = 3'd3,
        CSR_MEPC     = 3'd4,
        CSR_MCAUSE   = 3'd5,
        CSR_MTVAL    = 3'd6,
        CSR_MIP      = 3'd7
    } csr_register;

    localparam logic [11:0] CSR_ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_ADDR_MIE      = 12'h304;
    localparam logic [11:0] CSR_ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_ADDR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_ADDR_MIP      = 12'h344;

    localparam logic [1:0] CSR_OP_RW = 2'b01;
    localparam logic [1:0] CSR_OP_RS = 2'b10;
    localparam logic [1:0] CSR_OP_RC = 2'b11;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MSTATUS_MPP_LSB  = 11;
    localparam int unsigned MSTATUS_MPP_MSB  = 12;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CSR_RD,
        ST_CSR_WR,
        ST_T_EPC,
        ST_T_CAUSE,
        ST_T_TVAL,
        ST_T_STATUS,
        ST_T_VEC,
        ST_R_STATUS,
        ST_R_EPC
    } ctl_state_e;

endpackage

// File: rtl/csr_trap_controller_decoder.sv
// Maps a 12-bit CSR address onto the implemented CSR file select.
module csr_addr_decoder
    import csr_trap_controller_pkg::*;
(
    input  logic [11:0]  addr,
    output logic         valid,
    output csr_register  sel
);

    always_comb begin
        valid = 1'b1;
        sel   = CSR_MSTATUS;
        case (addr)
            CSR_ADDR_MSTATUS:  sel = CSR_MSTATUS;
            CSR_ADDR_MIE:      sel = CSR_MIE;
            CSR_ADDR_MTVEC:    sel = CSR_MTVEC;
            CSR_ADDR_MSCRATCH: sel = CSR_MSCRATCH;
            CSR_ADDR_MEPC:     sel = CSR_MEPC;
            CSR_ADDR_MCAUSE:   sel = CSR_MCAUSE;
            CSR_ADDR_MTVAL:    sel = CSR_MTVAL;
            CSR_ADDR_MIP:      sel = CSR_MIP;
            default:           valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/csr_trap_controller.sv
// Sequences CSR read-modify-write instructions, trap entry and mret against an
// external CSR file through a single select/read/write port.
module csr_trap_controller
    import csr_trap_controller_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_csr_req,
    input  logic [11:0]      i_csr_addr,
    input  logic [1:0]       i_csr_op,
    input  logic [XLEN-1:0]  i_csr_wdata,
    output logic             o_csr_ack,
    output logic [XLEN-1:0]  o_csr_rdata,
    output logic             o_csr_illegal,
    input  logic             i_trap_req,
    input  logic [XLEN-1:0]  i_trap_pc,
    input  logic [XLEN-1:0]  i_trap_cause,
    input  logic [XLEN-1:0]  i_trap_tval,
    input  logic             i_mret_req,
    output logic             o_trap_ack,
    output logic             o_mret_ack,
    output csr_register      o_rf_sel,
    output logic             o_rf_we,
    output logic [XLEN-1:0]  o_rf_wdata,
    input  logic [XLEN-1:0]  i_rf_rdata,
    output logic             o_redirect,
    output logic [XLEN-1:0]  o_redirect_pc
);

    ctl_state_e        state_q, state_d;
    csr_register       sel_q;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   operand_q, old_q, pc_q, cause_q, tval_q;
    logic              dec_valid;
    csr_register       dec_sel;
    logic              idle, accept_trap, accept_csr;
    logic [XLEN-1:0]   vec_base, vec_target, csr_result;

    csr_addr_decoder u_addr_decoder (
        .addr  (i_csr_addr),
        .valid (dec_valid),
        .sel   (dec_sel)
    );

    assign idle        = (state_q == ST_IDLE);
    assign accept_trap = idle && i_trap_req;
    assign accept_csr  = idle && !i_trap_req && !i_mret_req && i_csr_req;

    assign vec_base   = {i_rf_rdata[XLEN-1:2], 2'b00};
    assign vec_target = (i_rf_rdata[1:0] == 2'b01 && cause_q[XLEN-1])
                      ? vec_base + {cause_q[XLEN-3:0], 2'b00}
                      : vec_base;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= CSR_MSTATUS;
            op_q      <= '0;
            operand_q <= '0;
            old_q     <= '0;
            pc_q      <= '0;
            cause_q   <= '0;
            tval_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept_trap) begin
                pc_q    <= i_trap_pc;
                cause_q <= i_trap_cause;
                tval_q  <= i_trap_tval;
            end
            if (accept_csr) begin
                sel_q     <= dec_sel;
                op_q      <= i_csr_op;
                operand_q <= i_csr_wdata;
            end
            if (state_q == ST_CSR_RD) begin
                old_q <= i_rf_rdata;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        o_csr_ack     = 1'b0;
        o_csr_rdata   = '0;
        o_csr_illegal = 1'b0;
        o_trap_ack    = 1'b0;
        o_mret_ack    = 1'b0;
        o_rf_sel      = CSR_MSTATUS;
        o_rf_we       = 1'b0;
        o_rf_wdata    = '0;
        o_redirect    = 1'b0;
        o_redirect_pc = '0;
        csr_result    = '0;
        case (state_q)
            ST_IDLE: begin
                // Reset gates the combinational illegal-ack so outputs read 0 throughout reset.
                if (i_rst_n) begin
                    if (i_trap_req) begin
                        state_d = ST_T_EPC;
                    end else if (i_mret_req) begin
                        state_d = ST_R_STATUS;
                    end else if (i_csr_req) begin
                        if (dec_valid && i_csr_op != 2'b00) begin
                            state_d = ST_CSR_RD;
                        end else begin
                            o_csr_ack     = 1'b1;
                            o_csr_illegal = 1'b1;
                        end
                    end
                end
            end
            ST_CSR_RD: begin
                o_rf_sel = sel_q;
                state_d  = ST_CSR_WR;
            end
            ST_CSR_WR: begin
                o_rf_sel    = sel_q;
                o_csr_ack   = 1'b1;
                o_csr_rdata = old_q;
                case (op_q)
                    CSR_OP_RS: csr_result = old_q | operand_q;
                    CSR_OP_RC: csr_result = old_q & ~operand_q;
                    default:   csr_result = operand_q;
                endcase
                o_rf_we    = (op_q == CSR_OP_RW) || (operand_q != '0);
                o_rf_wdata = o_rf_we ? csr_result : '0;
                state_d    = ST_IDLE;
            end
            ST_T_EPC: begin
                o_rf_sel   = CSR_MEPC;
                o_rf_we    = 1'b1;
                o_rf_wdata = {pc_q[XLEN-1:2], 2'b00};
                state_d    = ST_T_CAUSE;
            end
            ST_T_CAUSE: begin
                o_rf_sel   = CSR_MCAUSE;
                o_rf_we    = 1'b1;
                o_rf_wdata = cause_q;
                state_d    = ST_T_TVAL;
            end
            ST_T_TVAL: begin
                o_rf_sel   = CSR_MTVAL;
                o_rf_we    = 1'b1;
                o_rf_wdata = tval_q;
                state_d    = ST_T_STATUS;
            end
            ST_T_STATUS: begin
                o_rf_sel   = CSR_MSTATUS;
                o_rf_we    = 1'b1;
                o_rf_wdata = i_rf_rdata;
                o_rf_wdata[MSTATUS_MPIE_BIT] = i_rf_rdata[MSTATUS_MIE_BIT];
                o_rf_wdata[MSTATUS_MIE_BIT]  = 1'b0;
                o_rf_wdata[MSTATUS_MPP_MSB:MSTATUS_MPP_LSB] = 2'b11;
                state_d    = ST_T_VEC;
            end
            ST_T_VEC: begin
                o_rf_sel      = CSR_MTVEC;
                o_redirect    = 1'b1;
                o_redirect_pc = vec_target;
                o_trap_ack    = 1'b1;
                state_d       = ST_IDLE;
            end
            ST_R_STATUS: begin
                o_rf_sel   = CSR_MSTATUS;
                o_rf_we    = 1'b1;
                o_rf_wdata = i_rf_rdata;
                o_rf_wdata[MSTATUS_MIE_BIT]  = i_rf_rdata[MSTATUS_MPIE_BIT];
                o_rf_wdata[MSTATUS_MPIE_BIT] = 1'b1;
                o_rf_wdata[MSTATUS_MPP_MSB:MSTATUS_MPP_LSB] = 2'b11;
                state_d    = ST_R_EPC;
            end
            ST_R_EPC: begin
                o_rf_sel      = CSR_MEPC;
                o_redirect    = 1'b1;
                o_redirect_pc = {i_rf_rdata[XLEN-1:2], 2'b00};
                o_mret_ack    = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_trap_controller.sv
// Randomized scoreboard bench: a behavioural CSR/trap model queues expected
// events, an independent monitor checks every write, ack and redirect.
`timescale 1ns/1ps
module tb_csr_trap_controller;
    import csr_trap_controller_pkg::*;

    localparam int EV_WR = 0, EV_CSR = 1, EV_TRAP = 2, EV_MRET = 3;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_req = 1'b0, trap_req = 1'b0, mret_req = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [1:0]  csr_op = '0;
    logic [31:0] csr_wdata = '0, trap_pc = '0, trap_cause = '0, trap_tval = '0;
    logic        csr_ack, csr_illegal, trap_ack, mret_ack, rf_we, redirect;
    logic [31:0] csr_rdata, rf_wdata, rf_rdata, redirect_pc;
    csr_register rf_sel;
    logic [2:0]  sel_idx;

    logic [31:0] env_csr [8];
    logic        tb_we = 1'b0;
    logic [2:0]  tb_idx = '0;
    logic [31:0] tb_val = '0;

    logic [31:0] m_csr [8];
    ev_t         q [$];
    int          tests = 0;
    int          fails = 0;
    logic [11:0] valid_addrs [8] = '{12'h300, 12'h304, 12'h305, 12'h340,
                                     12'h341, 12'h342, 12'h343, 12'h344};

    always #5 clk = ~clk;

    csr_trap_controller #(.XLEN(32)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_csr_req     (csr_req),
        .i_csr_addr    (csr_addr),
        .i_csr_op      (csr_op),
        .i_csr_wdata   (csr_wdata),
        .o_csr_ack     (csr_ack),
        .o_csr_rdata   (csr_rdata),
        .o_csr_illegal (csr_illegal),
        .i_trap_req    (trap_req),
        .i_trap_pc     (trap_pc),
        .i_trap_cause  (trap_cause),
        .i_trap_tval   (trap_tval),
        .i_mret_req    (mret_req),
        .o_trap_ack    (trap_ack),
        .o_mret_ack    (mret_ack),
        .o_rf_sel      (rf_sel),
        .o_rf_we       (rf_we),
        .o_rf_wdata    (rf_wdata),
        .i_rf_rdata    (rf_rdata),
        .o_redirect    (redirect),
        .o_redirect_pc (redirect_pc)
    );

    // CSR file storage seen by the DUT; bench preloads take priority over DUT writes.
    assign sel_idx  = rf_sel;
    assign rf_rdata = env_csr[sel_idx];
    always @(posedge clk) begin
        if (tb_we) env_csr[tb_idx] <= tb_val;
        else if (rf_we) env_csr[sel_idx] <= rf_wdata;
    end

    function automatic int addr_to_idx(input logic [11:0] a);
        case (a)
            12'h300: return int'(CSR_MSTATUS);
            12'h304: return int'(CSR_MIE);
            12'h305: return int'(CSR_MTVEC);
            12'h340: return int'(CSR_MSCRATCH);
            12'h341: return int'(CSR_MEPC);
            12'h342: return int'(CSR_MCAUSE);
            12'h343: return int'(CSR_MTVAL);
            12'h344: return int'(CSR_MIP);
            default: return -1;
        endcase
    endfunction

    task automatic push_ev(input int kind, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        e.kind = kind;
        e.a = a;
        e.b = b;
        q.push_back(e);
    endtask

    task automatic check_event(input int kind, input logic [31:0] a, input logic [31:0] b,
                               input string name);
        ev_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL %s unexpected: got a=%h b=%h, required no event", name, a, b);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.a !== a || e.b !== b) begin
                fails++;
                $display("FAIL %s: got kind=%0d a=%h b=%h, required kind=%0d a=%h b=%h",
                         name, kind, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    // Monitor: every DUT event must match the head of the expectation queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rf_we) begin
                    check_event(EV_WR, {29'b0, sel_idx}, rf_wdata, "rf_write");
                end else begin
                    tests++;
                    if (rf_wdata !== '0) begin
                        fails++;
                        $display("FAIL idle_wdata: got %h, required 0", rf_wdata);
                    end
                end
                if (csr_ack) check_event(EV_CSR, csr_rdata, {31'b0, csr_illegal}, "csr_ack");
                if (trap_ack) check_event(EV_TRAP, redirect_pc, {31'b0, redirect}, "trap_ack");
                if (mret_ack) check_event(EV_MRET, redirect_pc, {31'b0, redirect}, "mret_ack");
                if (redirect && !trap_ack && !mret_ack) begin
                    tests++;
                    fails++;
                    $display("FAIL stray_redirect: got redirect=1 pc=%h, required 0", redirect_pc);
                end
                if (!redirect) begin
                    tests++;
                    if (redirect_pc !== '0) begin
                        fails++;
                        $display("FAIL idle_redirect_pc: got %h, required 0", redirect_pc);
                    end
                end
            end
        end
    end

    task automatic check_zero(input string name);
        logic [133:0] all;
        all = {csr_ack, csr_rdata, csr_illegal, trap_ack, mret_ack, sel_idx,
               rf_we, rf_wdata, redirect, redirect_pc};
        tests++;
        if (all !== '0) begin
            fails++;
            $display("FAIL %s: got outputs %h, required all 0", name, all);
        end
    endtask

    task automatic set_csr(input int idx, input logic [31:0] val);
        m_csr[idx] = val;
        tb_idx = 3'(idx);
        tb_val = val;
        tb_we = 1'b1;
        @(posedge clk);
        #1;
        tb_we = 1'b0;
    endtask

    task automatic expect_csr(input logic [11:0] addr, input logic [1:0] op,
                              input logic [31:0] opnd, output int lat);
        int idx;
        logic [31:0] old, nv;
        idx = addr_to_idx(addr);
        if (idx < 0 || op == 2'b00) begin
            push_ev(EV_CSR, 32'h0, 32'h1);
            lat = 0;
        end else begin
            old = m_csr[idx];
            if (op == 2'b01) nv = opnd;
            else if (op == 2'b10) nv = old | opnd;
            else nv = old & ~opnd;
            if (op == 2'b01 || opnd != 0) begin
                push_ev(EV_WR, 32'(idx), nv);
                m_csr[idx] = nv;
            end
            push_ev(EV_CSR, old, 32'h0);
            lat = 2;
        end
    endtask

    task automatic expect_trap(input logic [31:0] pc, input logic [31:0] cause,
                               input logic [31:0] tval);
        logic [31:0] st, nst, base, tgt, mtvec;
        m_csr[int'(CSR_MEPC)] = pc & ~32'h3;
        push_ev(EV_WR, 32'(int'(CSR_MEPC)), pc & ~32'h3);
        m_csr[int'(CSR_MCAUSE)] = cause;
        push_ev(EV_WR, 32'(int'(CSR_MCAUSE)), cause);
        m_csr[int'(CSR_MTVAL)] = tval;
        push_ev(EV_WR, 32'(int'(CSR_MTVAL)), tval);
        st = m_csr[int'(CSR_MSTATUS)];
        nst = (st & ~32'h1888) | (((st >> 3) & 32'h1) << 7) | 32'h1800;
        m_csr[int'(CSR_MSTATUS)] = nst;
        push_ev(EV_WR, 32'(int'(CSR_MSTATUS)), nst);
        mtvec = m_csr[int'(CSR_MTVEC)];
        base = mtvec & ~32'h3;
        if ((mtvec & 32'h3) == 32'h1 && cause[31]) tgt = base + (cause & 32'h7FFF_FFFF) * 4;
        else tgt = base;
        push_ev(EV_TRAP, tgt, 32'h1);
    endtask

    task automatic expect_mret();
        logic [31:0] st, nst;
        st = m_csr[int'(CSR_MSTATUS)];
        nst = (st & ~32'h1888) | (((st >> 7) & 32'h1) << 3) | 32'h80 | 32'h1800;
        m_csr[int'(CSR_MSTATUS)] = nst;
        push_ev(EV_WR, 32'(int'(CSR_MSTATUS)), nst);
        push_ev(EV_MRET, m_csr[int'(CSR_MEPC)] & ~32'h3, 32'h1);
    endtask

    task automatic wait_ack(input int kind, input int exp_lat, input string name);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n <= 40) begin
            @(negedge clk);
            if (kind == EV_CSR) got = csr_ack;
            else if (kind == EV_TRAP) got = trap_ack;
            else got = mret_ack;
            if (!got) n++;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s_timeout: got no ack in 40 cycles, required ack after %0d", name, exp_lat);
        end else if (n != exp_lat) begin
            fails++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, n, exp_lat);
        end
        @(posedge clk);
        #1;
        if (kind == EV_CSR) csr_req = 1'b0;
        else if (kind == EV_TRAP) trap_req = 1'b0;
        else mret_req = 1'b0;
    endtask

    task automatic issue_csr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] opnd);
        int lat;
        expect_csr(addr, op, opnd, lat);
        csr_addr = addr;
        csr_op = op;
        csr_wdata = opnd;
        csr_req = 1'b1;
        wait_ack(EV_CSR, lat, "csr");
    endtask

    task automatic issue_trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval);
        expect_trap(pc, cause, tval);
        trap_pc = pc;
        trap_cause = cause;
        trap_tval = tval;
        trap_req = 1'b1;
        wait_ack(EV_TRAP, 5, "trap");
    endtask

    task automatic issue_mret();
        expect_mret();
        mret_req = 1'b1;
        wait_ack(EV_MRET, 2, "mret");
    endtask

    task automatic check_queue_empty(input string name);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s: got %0d pending expectations, required 0", name, q.size());
        end
    endtask

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got simulation still running, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        int lat;
        int kind;
        logic [11:0] a;
        logic [31:0] v, c;

        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) set_csr(i, $urandom);
        @(negedge clk);
        check_zero("in_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("after_reset");
        @(posedge clk);
        #1;

        // Directed scenarios
        set_csr(int'(CSR_MSTATUS), 32'h1800);
        issue_csr(12'h300, 2'b10, 32'h8);
        issue_csr(12'h7C0, 2'b01, 32'h1234_5678);
        issue_csr(12'h340, 2'b00, 32'hFFFF_FFFF);
        issue_csr(12'h340, 2'b10, 32'h0);
        issue_csr(12'h340, 2'b11, 32'h0);
        issue_csr(12'h340, 2'b01, 32'h0);
        issue_csr(12'h340, 2'b11, 32'h0000_00F0);

        set_csr(int'(CSR_MTVEC), 32'h201);
        set_csr(int'(CSR_MSTATUS), 32'h8);
        issue_trap(32'h100, 32'h8000_0007, 32'hDEAD_BEEF);
        set_csr(int'(CSR_MEPC), 32'h104);
        issue_mret();

        set_csr(int'(CSR_MTVEC), 32'h300);
        issue_trap(32'h203, 32'h8000_0003, 32'h0);
        set_csr(int'(CSR_MTVEC), 32'hFFFF_FFF1);
        issue_trap(32'h400, 32'h8000_0010, 32'h1);
        issue_trap(32'h404, 32'h0000_0002, 32'h2);

        // Simultaneous requests: trap first, then mret, then CSR
        expect_trap(32'h8000, 32'h8000_000B, 32'h55);
        expect_mret();
        expect_csr(12'h340, 2'b01, 32'hA5A5_0000, lat);
        trap_pc = 32'h8000;
        trap_cause = 32'h8000_000B;
        trap_tval = 32'h55;
        csr_addr = 12'h340;
        csr_op = 2'b01;
        csr_wdata = 32'hA5A5_0000;
        trap_req = 1'b1;
        mret_req = 1'b1;
        csr_req = 1'b1;
        wait_ack(EV_TRAP, 5, "prio_trap");
        wait_ack(EV_MRET, 2, "prio_mret");
        wait_ack(EV_CSR, lat, "prio_csr");

        // Reset while writing mcause: only the mepc write may have landed
        m_csr[int'(CSR_MEPC)] = 32'h600;
        push_ev(EV_WR, 32'(int'(CSR_MEPC)), 32'h600);
        trap_pc = 32'h602;
        trap_cause = 32'h5;
        trap_tval = 32'h9;
        trap_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        trap_req = 1'b0;
        #1;
        check_zero("reset_mid_trap");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_queue_empty("reset_abort_queue");
        issue_csr(12'h341, 2'b10, 32'h0000_0001);
        issue_csr(12'h342, 2'b01, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 1) begin
                c = $urandom;
                if ($urandom_range(0, 1) == 1) c = c & 32'h8000_003F;
                issue_trap($urandom, c, $urandom);
            end else if (kind == 2) begin
                issue_mret();
            end else if (kind == 3) begin
                v = $urandom;
                if ($urandom_range(0, 1) == 1) v = (v & ~32'h3) | 32'h1;
                set_csr(int'(CSR_MTVEC), v);
            end else begin
                if ($urandom_range(0, 4) == 0) a = 12'($urandom);
                else a = valid_addrs[$urandom_range(0, 7)];
                v = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
                issue_csr(a, 2'($urandom_range(0, 3)), v);
            end
        end

        repeat (3) @(posedge clk);
        check_queue_empty("final_queue");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
